// File: rtl/imem_loader.sv
// imem_loader: streams bytes from a valid/ready source into 32-bit instruction
// memory words and holds the core in reset while the image is loading.
//
// Ports:
//   clk, rst          single clock, synchronous active-high reset
//   start, len        one-cycle load request and its word count (sampled in IDLE)
//   in_valid, in_data byte stream, least-significant byte of each word first
//   in_ready          byte accepted when in_valid && in_ready
//   we, w_addr, w_data  one-cycle write of each assembled word
//   core_rst          rst OR busy
//   busy              load in progress (LOAD/WRITE)
//   done              one-cycle pulse when a load completes
//   err               one-cycle pulse when a start is rejected (len > MAX_WORDS)
module imem_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned MAX_WORDS = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] len,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        we,
    output logic [31:0] w_addr,
    output logic [31:0] w_data,
    output logic        core_rst,
    output logic        busy,
    output logic        done,
    output logic        err
);

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StWrite,
        StDone
    } state_e;

    state_e      state_q, state_d;
    logic [15:0] len_q, len_d;
    logic [15:0] word_idx_q, word_idx_d;
    logic [1:0]  byte_cnt_q, byte_cnt_d;
    logic [31:0] asm_q, asm_d;
    logic [31:0] w_addr_q, w_addr_d;
    logic [31:0] w_data_q, w_data_d;
    logic        err_q, err_d;

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        word_idx_d = word_idx_q;
        byte_cnt_d = byte_cnt_q;
        asm_d      = asm_q;
        w_addr_d   = w_addr_q;
        w_data_d   = w_data_q;
        err_d      = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    if (len == 16'd0) begin
                        state_d = StDone;
                    end else if (32'(len) > MAX_WORDS) begin
                        err_d = 1'b1;
                    end else begin
                        state_d    = StLoad;
                        len_d      = len;
                        word_idx_d = 16'd0;
                        byte_cnt_d = 2'd0;
                        asm_d      = 32'd0;
                    end
                end
            end
            StLoad: begin
                if (in_valid) begin
                    asm_d[{byte_cnt_q, 3'b000} +: 8] = in_data;
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        // Capture the write now so we/w_addr/w_data line up in WRITE.
                        state_d  = StWrite;
                        w_data_d = asm_d;
                        w_addr_d = BASE_ADDR + {14'd0, word_idx_q, 2'b00};
                    end
                end
            end
            StWrite: begin
                if (word_idx_q + 16'd1 == len_q) begin
                    state_d = StDone;
                end else begin
                    word_idx_d = word_idx_q + 16'd1;
                    state_d    = StLoad;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            len_q      <= 16'd0;
            word_idx_q <= 16'd0;
            byte_cnt_q <= 2'd0;
            asm_q      <= 32'd0;
            w_addr_q   <= 32'd0;
            w_data_q   <= 32'd0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            word_idx_q <= word_idx_d;
            byte_cnt_q <= byte_cnt_d;
            asm_q      <= asm_d;
            w_addr_q   <= w_addr_d;
            w_data_q   <= w_data_d;
            err_q      <= err_d;
        end
    end

    // Outputs decode the registered state; rst masks them so a reset asserted
    // mid-load drops every strobe in the same cycle.
    assign in_ready = (state_q == StLoad) && !rst;
    assign we       = (state_q == StWrite) && !rst;
    assign busy     = ((state_q == StLoad) || (state_q == StWrite)) && !rst;
    assign done     = (state_q == StDone) && !rst;
    assign err      = err_q && !rst;
    assign core_rst = rst | busy;
    assign w_addr   = w_addr_q;
    assign w_data   = w_data_q;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: stimulus pushes expected write/done/err
// events; a monitor pops and compares whenever the DUT emits one.
module tb_imem_loader;

    localparam logic [31:0] BASE = 32'h0000_0000;
    localparam int          MAXW = 256;

    logic        clk = 1'b0;
    logic        rst, start, in_valid;
    logic [15:0] len;
    logic [7:0]  in_data;
    logic        in_ready, we, core_rst, busy, done, err;
    logic [31:0] w_addr, w_data;

    imem_loader #(
        .BASE_ADDR(BASE),
        .MAX_WORDS(MAXW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .len(len),
        .in_valid(in_valid),
        .in_data(in_data),
        .in_ready(in_ready),
        .we(we),
        .w_addr(w_addr),
        .w_data(w_data),
        .core_rst(core_rst),
        .busy(busy),
        .done(done),
        .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          kind;  // 0 write, 1 done, 2 err
        logic [31:0] addr;
        logic [31:0] data;
    } ev_t;

    ev_t         exp_q[$];
    int          tests = 0;
    int          fails = 0;
    int          cyc = 0;
    int          last_we_cyc = -1, last_done_cyc = -1, last_err_cyc = -1;
    int          we_cnt = 0;
    logic [31:0] last_we_addr = 32'hdead_beef;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic push_ev(input int kind, input logic [31:0] addr, input logic [31:0] data);
        ev_t e;
        e.kind = kind;
        e.addr = addr;
        e.data = data;
        exp_q.push_back(e);
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Monitor: compares every emitted event against the scoreboard head.
    initial forever begin
        int nev;
        ev_t e;
        @(negedge clk);
        check("core_rst", {31'd0, core_rst}, {31'd0, rst | busy});
        if (in_ready && !busy) check("in_ready_without_busy", 32'd1, 32'd0);
        nev = int'(we) + int'(done) + int'(err);
        if (nev > 1) begin
            check("simultaneous_events", nev, 1);
        end else if (nev == 1) begin
            if (we) begin
                last_we_cyc  = cyc;
                last_we_addr = w_addr;
                we_cnt++;
            end
            if (done) last_done_cyc = cyc;
            if (err) last_err_cyc = cyc;
            if (exp_q.size() == 0) begin
                check("unexpected_event", {29'd0, we, done, err}, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("event_kind", we ? 0 : (done ? 1 : 2), e.kind);
                if (we && e.kind == 0) begin
                    check("w_addr", w_addr, e.addr);
                    check("w_data", w_data, e.data);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called #1 after an edge; returns k = cycle count just after the sampling edge.
    task automatic do_start(input logic [15:0] l, output int k);
        start = 1'b1;
        len   = l;
        tick();
        k     = cyc;
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap_max);
        int g, t;
        g = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
        in_valid = 1'b0;
        repeat (g) tick();
        in_valid = 1'b1;
        in_data  = b;
        t = 0;
        while (!in_ready && t < 20) begin
            tick();
            t++;
        end
        if (t >= 20) check("byte_accept_timeout", 32'd0, 32'd1);
        check("busy_during_load", {30'd0, busy, core_rst}, 32'd3);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input int first_b, input int last_b,
                             input int gap_max);
        for (int b = first_b; b <= last_b; b++) send_byte(w[8*b +: 8], gap_max);
    endtask

    task automatic drain(input string nm);
        int t = 0;
        while (exp_q.size() != 0 && t < 200) begin
            tick();
            t++;
        end
        check(nm, exp_q.size(), 0);
        repeat (3) tick();
    endtask

    // Reference: word i lands at BASE + 4*i, then one done.
    task automatic load_words(input logic [31:0] ws[$], input int gap_max, output int k);
        for (int i = 0; i < ws.size(); i++) push_ev(0, BASE + 32'(4 * i), ws[i]);
        push_ev(1, 32'd0, 32'd0);
        do_start(16'(ws.size()), k);
        for (int i = 0; i < ws.size(); i++) send_word(ws[i], 0, 3, gap_max);
        drain("load_drain");
    endtask

    initial begin
        logic [31:0] ws[$];
        int k, n, wc0;

        rst = 1'b1; start = 1'b0; len = 16'd0; in_valid = 1'b0; in_data = 8'd0;
        tick();
        tick();
        check("rst_outputs", {27'd0, we, in_ready, busy, done, err}, 32'd0);
        check("rst_core_rst", {31'd0, core_rst}, 32'd1);
        rst = 1'b0;
        tick();
        check("post_rst_outputs", {26'd0, we, in_ready, busy, done, err, core_rst}, 32'd0);
        check("post_rst_w_addr", w_addr, 32'd0);
        check("post_rst_w_data", w_data, 32'd0);

        // Single word, back-to-back bytes, latency.
        ws = {32'h0000_0013};
        load_words(ws, 0, k);
        check("we_latency", last_we_cyc, k + 4);
        check("done_latency", last_done_cyc, k + 5);

        // Multi-word with random gaps.
        ws = {32'h1122_3344, 32'hAABB_CCDD, 32'h0000_0073};
        load_words(ws, 3, k);

        // len = 0: done the cycle after start, no byte accepted.
        push_ev(1, 32'd0, 32'd0);
        in_valid = 1'b1;
        do_start(16'd0, k);
        check("len0_in_ready", {31'd0, in_ready}, 32'd0);
        tick();
        check("len0_in_ready_after", {31'd0, in_ready}, 32'd0);
        in_valid = 1'b0;
        drain("len0_drain");
        check("len0_done_cyc", last_done_cyc, k);

        // len = MAX_WORDS+1: err pulse, stays idle.
        push_ev(2, 32'd0, 32'd0);
        do_start(16'(MAXW + 1), k);
        check("err_idle_busy", {30'd0, busy, in_ready}, 32'd0);
        drain("err_drain");
        check("err_cyc", last_err_cyc, k);

        // Random loads.
        repeat (4) begin
            n = int'($urandom_range(1, 6));
            ws.delete();
            for (int i = 0; i < n; i++) ws.push_back($urandom);
            load_words(ws, 2, k);
        end

        // len = MAX_WORDS.
        ws.delete();
        for (int i = 0; i < MAXW; i++) ws.push_back($urandom);
        load_words(ws, 0, k);
        check("maxw_last_addr", last_we_addr, BASE + 32'(4 * (MAXW - 1)));

        // Start while busy is ignored.
        ws = {$urandom, $urandom};
        wc0 = we_cnt;
        push_ev(0, BASE, ws[0]);
        push_ev(0, BASE + 32'd4, ws[1]);
        push_ev(1, 32'd0, 32'd0);
        do_start(16'd2, k);
        send_word(ws[0], 0, 2, 1);
        start = 1'b1;
        len   = 16'd5;
        tick();
        start = 1'b0;
        send_word(ws[0], 3, 3, 1);
        send_word(ws[1], 0, 3, 1);
        drain("busy_start_drain");
        check("busy_start_writes", we_cnt - wc0, 2);

        // Reset mid-word: only word 0 is written, no done.
        ws = {$urandom, $urandom};
        push_ev(0, BASE, ws[0]);
        do_start(16'd2, k);
        send_word(ws[0], 0, 3, 1);
        send_word(ws[1], 0, 1, 1);
        rst = 1'b1;
        #1;
        check("midrst_outputs", {27'd0, we, in_ready, busy, done, err}, 32'd0);
        check("midrst_core_rst", {31'd0, core_rst}, 32'd1);
        tick();
        rst = 1'b0;
        tick();
        check("midrst_idle", {29'd0, busy, in_ready, core_rst}, 32'd0);
        check("midrst_w_addr", w_addr, 32'd0);
        check("midrst_w_data", w_data, 32'd0);
        drain("midrst_drain");
        ws = {$urandom};
        load_words(ws, 1, k);
        check("fresh_load_addr", last_we_addr, BASE);

        check("final_queue_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter BASE_ADDR, default 32'h0000_0000, byte address written by the first loaded word.
REQ-002 Parameter MAX_WORDS, default 256, largest word count accepted per load.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset; one clock; reset is synchronous and active-high.
REQ-005 start  input  1  one-cycle request to begin a load; sampled only in IDLE.
REQ-006 len  input  16  number of 32-bit words to load; sampled with start.
REQ-007 in_valid  input  1  byte-stream source has a byte on in_data.
REQ-008 in_data  input  8  byte-stream payload, least-significant byte of each word first.
REQ-009 in_ready  output  1  loader accepts a byte this cycle; a byte transfers when in_valid and in_ready are both 1.
REQ-010 we  output  1  instruction-memory write enable, one cycle per word.
REQ-011 w_addr  output  32  instruction-memory byte address, valid when we=1.
REQ-012 w_data  output  32  instruction-memory write word, valid when we=1.
REQ-013 core_rst  output  1  holds the core (pc and fetch path) in reset while loading.
REQ-014 busy  output  1  load in progress.
REQ-015 done  output  1  one-cycle pulse when a load completes.
REQ-016 err  output  1  one-cycle pulse when a start is rejected.

Function
REQ-017 The state machine SHALL have the states IDLE, LOAD, WRITE and DONE.
REQ-018 IDLE: start=1 with 0 < len <= MAX_WORDS -> LOAD next cycle; word_idx=0; byte_cnt=0; len is latched.
REQ-019 IDLE: start=1 with len=0 -> DONE next cycle; no byte is accepted; no write occurs.
REQ-020 IDLE: start=1 with len > MAX_WORDS -> err=1 for the next cycle; the block stays in IDLE.
REQ-021 LOAD: in_ready=1; each transfer stores in_data into byte lane byte_cnt (bits 8*byte_cnt+7 : 8*byte_cnt) and increments byte_cnt modulo 4.
REQ-022 LOAD: the transfer with byte_cnt=3 -> WRITE next cycle.
REQ-023 LOAD: in_valid=0 -> hold all state indefinitely; there is no timeout.
REQ-024 WRITE: exactly one cycle; we=1; w_addr = BASE_ADDR + 4*word_idx (32-bit, wraps modulo 2^32); w_data = assembled word; in_ready=0.
REQ-025 WRITE exit: word_idx+1 == latched len -> DONE; otherwise word_idx increments and the state returns to LOAD.
REQ-026 DONE: exactly one cycle; done=1; then IDLE.
REQ-027 busy=1 in LOAD and WRITE only; in_ready=0 outside LOAD; we=0 outside WRITE.
REQ-028 core_rst = rst OR busy, combinational; core_rst=0 in IDLE and DONE when rst=0.
REQ-029 A start asserted while not in IDLE SHALL be ignored, with no err pulse and no change to the latched len.
REQ-030 Byte-to-write latency: the fourth byte of a word is accepted at edge N; we=1 during cycle N+1.
REQ-031 Minimum per-word throughput: 5 cycles (4 byte transfers plus 1 WRITE cycle).
REQ-032 w_addr and w_data SHALL hold their last values when we=0.

Reset
REQ-033 rst=1 at a clock edge -> state IDLE, word_idx=0, byte_cnt=0, assembly register=0, w_addr=0, w_data=0.
REQ-034 Outputs during and after reset: we=0, in_ready=0, busy=0, done=0, err=0; core_rst=1 while rst=1.
REQ-035 Reset mid-load SHALL discard any partial word, issue no further write, and leave already-written words unaltered.

Verification
REQ-036 Single word: start, len=1, bytes 13,00,00,00 streamed back-to-back -> one we pulse, w_addr=0x0, w_data=0x00000013; done the following cycle; 7 cycles from start to done.
REQ-037 Multi-word with gaps: len=3, bytes for 0x11223344, 0xAABBCCDD, 0x00000073, with random in_valid gaps -> writes at 0x0, 0x4, 0x8 with those words; busy=1 and core_rst=1 throughout; exactly one done pulse.
REQ-038 Boundaries: len=0 -> done one cycle after start, no we, in_ready never 1; len=MAX_WORDS+1 -> err pulse, state stays IDLE; len=MAX_WORDS -> last write at BASE_ADDR+4*(MAX_WORDS-1).
REQ-039 Reset mid-word: len=2, 6 bytes sent, rst pulsed -> exactly one write (word 0), no done, IDLE afterwards; a fresh load then starts again at BASE_ADDR.
REQ-040 Start while busy: start pulsed with len=5 during a len=2 load -> ignored; exactly 2 writes, no err.
